// File: rtl/fetch_pkg.sv
// Shared types and widths for the instruction fetch queue.
package fetch_pkg;

  localparam int unsigned XLEN        = 32;
  localparam int unsigned FETCH_WIDTH = 4;
  localparam int unsigned ISSUE_WIDTH = 2;
  localparam int unsigned INSTR_BYTES = 4;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } fq_entry_t;

  // PC of the idx-th word of a fetch group, wrapping mod 2^32.
  function automatic logic [XLEN-1:0] pc_offset(input logic [XLEN-1:0] base,
                                                input int unsigned     idx);
    return base + XLEN'(INSTR_BYTES * idx);
  endfunction

endpackage

// File: rtl/fetch_queue_if.sv
// Fetch-side and decode-side signal bundle of the fetch queue.
interface fetch_queue_if
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 16
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic                                flush;
  logic                                in_vld;
  logic [2:0]                          in_cnt;
  logic [XLEN-1:0]                     pc_in;
  logic [FETCH_WIDTH-1:0][XLEN-1:0]    instr_in;
  logic                                in_rdy;
  logic [ISSUE_WIDTH-1:0]              out_vld;
  logic [ISSUE_WIDTH-1:0][XLEN-1:0]    out_instr;
  logic [ISSUE_WIDTH-1:0][XLEN-1:0]    out_pc;
  logic [1:0]                          out_take;
  logic [CNT_W-1:0]                    count;

  modport slave (
    input  flush, in_vld, in_cnt, pc_in, instr_in, out_take,
    output in_rdy, out_vld, out_instr, out_pc, count
  );

  modport master (
    output flush, in_vld, in_cnt, pc_in, instr_in, out_take,
    input  in_rdy, out_vld, out_instr, out_pc, count
  );

endinterface

// File: rtl/fq_ram.sv
// Entry storage: DEPTH x {instr, pc} with 4 contiguous wrapped write ports
// and 2 combinational read ports.
module fq_ram
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  localparam int unsigned PTR_W = $clog2(DEPTH)
) (
  input  logic                                clk_i,
  input  logic [FETCH_WIDTH-1:0]              we_i,
  input  logic [PTR_W-1:0]                    waddr_i,
  input  fq_entry_t [FETCH_WIDTH-1:0]         wdata_i,
  input  logic [PTR_W-1:0]                    raddr0_i,
  input  logic [PTR_W-1:0]                    raddr1_i,
  output fq_entry_t                           rdata0_o,
  output fq_entry_t                           rdata1_o
);

  fq_entry_t mem_q [DEPTH];

  // Port i writes base+i; the pointer width makes the wrap implicit.
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      if (we_i[i]) begin
        mem_q[waddr_i + PTR_W'(i)] <= wdata_i[i];
      end
    end
  end

  assign rdata0_o = mem_q[raddr0_i];
  assign rdata1_o = mem_q[raddr1_i];

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch queue: 4-wide push, 2-wide present/pop, flush on redirect.
// Optional same-cycle empty-queue bypass under FETCH_QUEUE_BYPASS_EN.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 16
) (
  input  logic           clk_i,
  input  logic           reset_i,
  fetch_queue_if.slave   bus
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [PTR_W-1:0]           head_q, head_d;
  logic [PTR_W-1:0]           tail_q, tail_d;
  logic [CNT_W-1:0]           count_q, count_d;

  logic [2:0]                 grp_cnt_c;
  logic                       in_rdy_c;
  logic                       push_c;
  logic                       bypass_c;
  logic [CNT_W-1:0]           avail_c;
  logic [1:0]                 take_c;
  logic [1:0]                 pop_n_c;
  logic [1:0]                 shift_c;
  logic [1:0]                 hd_pop_c;
  logic [2:0]                 store_n_c;
  logic [FETCH_WIDTH-1:0]     we_c;
  fq_entry_t [FETCH_WIDTH-1:0] wdata_c;
  fq_entry_t                  rd0_c, rd1_c;

  // Push/pop accounting; bypassed words consumed this cycle are never stored.
  always_comb begin
    grp_cnt_c = (bus.in_cnt > 3'(FETCH_WIDTH)) ? 3'(FETCH_WIDTH) : bus.in_cnt;
    in_rdy_c  = (count_q <= CNT_W'(DEPTH - FETCH_WIDTH));
    push_c    = bus.in_vld && in_rdy_c && !bus.flush && (grp_cnt_c != 3'd0);
    bypass_c  = 1'b0;
`ifdef FETCH_QUEUE_BYPASS_EN
    bypass_c  = push_c && (count_q == '0);
`endif
    avail_c   = bypass_c ? CNT_W'(grp_cnt_c) : count_q;
    take_c    = (bus.out_take > 2'(ISSUE_WIDTH)) ? 2'(ISSUE_WIDTH) : bus.out_take;
    pop_n_c   = (CNT_W'(take_c) > avail_c) ? 2'(avail_c) : take_c;
    shift_c   = bypass_c ? pop_n_c : 2'd0;
    hd_pop_c  = bypass_c ? 2'd0 : pop_n_c;
    store_n_c = push_c ? (grp_cnt_c - 3'(shift_c)) : 3'd0;
  end

  // Write data, realigned past any words consumed through the bypass.
  always_comb begin
    we_c    = '0;
    wdata_c = '0;
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      we_c[i]          = (3'(i) < store_n_c);
      wdata_c[i].instr = bus.instr_in[2'(i) + shift_c];
      wdata_c[i].pc    = pc_offset(bus.pc_in, 32'(i) + 32'(shift_c));
    end
  end

  always_comb begin
    head_d  = head_q + PTR_W'(hd_pop_c);
    tail_d  = tail_q + PTR_W'(store_n_c);
    count_d = count_q + CNT_W'(store_n_c) - CNT_W'(hd_pop_c);
    if (bus.flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  fq_ram #(.DEPTH(DEPTH)) u_ram (
    .clk_i    (clk_i),
    .we_i     (we_c),
    .waddr_i  (tail_q),
    .wdata_i  (wdata_c),
    .raddr0_i (head_q),
    .raddr1_i (head_q + PTR_W'(1)),
    .rdata0_o (rd0_c),
    .rdata1_o (rd1_c)
  );

  // Decode-side view; invalid slots read as zero.
  always_comb begin
    bus.out_vld   = '0;
    bus.out_instr = '0;
    bus.out_pc    = '0;
    bus.out_vld[0] = (count_q >= CNT_W'(1));
    bus.out_vld[1] = (count_q >= CNT_W'(2));
    if (bus.out_vld[0]) begin
      bus.out_instr[0] = rd0_c.instr;
      bus.out_pc[0]    = rd0_c.pc;
    end
    if (bus.out_vld[1]) begin
      bus.out_instr[1] = rd1_c.instr;
      bus.out_pc[1]    = rd1_c.pc;
    end
`ifdef FETCH_QUEUE_BYPASS_EN
    if (bypass_c) begin
      bus.out_vld[0]   = 1'b1;
      bus.out_instr[0] = bus.instr_in[0];
      bus.out_pc[0]    = bus.pc_in;
      bus.out_vld[1]   = (grp_cnt_c >= 3'd2);
      bus.out_instr[1] = bus.out_vld[1] ? bus.instr_in[1] : '0;
      bus.out_pc[1]    = bus.out_vld[1] ? pc_offset(bus.pc_in, 1) : '0;
    end
`endif
  end

  assign bus.in_rdy = in_rdy_c;
  assign bus.count  = count_q;

`ifndef SYNTHESIS
  a_in_cnt_range: assert property (@(posedge clk_i) disable iff (reset_i)
    bus.in_vld |-> (bus.in_cnt <= 3'(FETCH_WIDTH)));
  a_take_range: assert property (@(posedge clk_i) disable iff (reset_i || bus.flush)
    CNT_W'(bus.out_take) <= avail_c);
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Scoreboard bench for fetch_queue; follows FETCH_QUEUE_BYPASS_EN if defined.
module tb_fetch_queue;
  import fetch_pkg::*;

  localparam int unsigned DEPTH = 16;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  fetch_queue_if #(.DEPTH(DEPTH)) bus ();

  fetch_queue #(.DEPTH(DEPTH)) dut (
    .clk_i   (clk),
    .reset_i (reset),
    .bus     (bus)
  );

  int errors = 0;
  int checks = 0;
  fq_entry_t sb[$];

  bit          m_v;
  int          m_n;
  logic [31:0] m_pc;
  int          m_take;
  bit          m_fl;

  task automatic set_in(input bit v, input int n, input logic [31:0] pc,
                        input int take, input bit fl);
    m_v = v; m_n = n; m_pc = pc; m_take = take; m_fl = fl;
    bus.in_vld   = v;
    bus.in_cnt   = 3'(n);
    bus.pc_in    = pc;
    for (int i = 0; i < 4; i++) bus.instr_in[i] = $urandom;
    bus.out_take = 2'(take);
    bus.flush    = fl;
    #1;
  endtask

  // Advance one edge and apply the reference queue behaviour.
  task automatic tick();
    int sz, avail, pop;
    bit acc;
    logic [31:0] words [4];
    sz  = sb.size();
    acc = !m_fl && m_v && (m_n > 0) && (sz <= int'(DEPTH) - 4);
    avail = sz;
`ifdef FETCH_QUEUE_BYPASS_EN
    if (sz == 0 && acc) avail = m_n;
`endif
    pop = (m_take < avail) ? m_take : avail;
    for (int i = 0; i < 4; i++) words[i] = bus.instr_in[i];
    @(posedge clk);
    if (m_fl) sb.delete();
    else begin
      if (acc) for (int i = 0; i < m_n; i++) sb.push_back('{instr: words[i], pc: m_pc + 32'(4 * i)});
      for (int i = 0; i < pop; i++) void'(sb.pop_front());
    end
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    set_in(0, 0, 0, 0, 0);
    sb.delete();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    checks++; if (bus.count !== 5'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", bus.count); end
    checks++; if (bus.in_rdy !== 1'b1) begin errors++; $display("FAIL reset_in_rdy got %b exp 1", bus.in_rdy); end
    checks++; if (bus.out_vld !== 2'b00) begin errors++; $display("FAIL reset_out_vld got %b exp 00", bus.out_vld); end
    checks++; if (bus.out_instr !== 64'd0 || bus.out_pc !== 64'd0) begin
      errors++; $display("FAIL reset_outputs got instr=%h pc=%h exp 0", bus.out_instr, bus.out_pc); end
  endtask

  task automatic test_push_pop();
    set_in(1, 4, 32'h100, 0, 0); tick(); set_in(0, 0, 0, 0, 0);
    checks++; if (bus.count !== 5'd4) begin errors++; $display("FAIL pp_count got %0d exp 4", bus.count); end
    checks++; if (bus.out_pc[0] !== 32'h100 || bus.out_pc[1] !== 32'h104) begin
      errors++; $display("FAIL pp_pcs got %h %h exp 100 104", bus.out_pc[0], bus.out_pc[1]); end
    checks++; if (bus.out_instr[0] !== sb[0].instr || bus.out_instr[1] !== sb[1].instr) begin
      errors++; $display("FAIL pp_instr got %h %h exp %h %h", bus.out_instr[0], bus.out_instr[1], sb[0].instr, sb[1].instr); end
    set_in(0, 0, 0, 2, 0); tick(); set_in(0, 0, 0, 0, 0);
    checks++; if (bus.out_pc[0] !== 32'h108 || bus.count !== 5'd2) begin
      errors++; $display("FAIL pp_after_take got pc=%h cnt=%0d exp 108 2", bus.out_pc[0], bus.count); end
    checks++; if (bus.out_instr[0] !== sb[0].instr) begin
      errors++; $display("FAIL pp_after_take_instr got %h exp %h", bus.out_instr[0], sb[0].instr); end
    set_in(0, 0, 0, 2, 0); tick(); set_in(0, 0, 0, 0, 0);
    checks++; if (bus.count !== 5'd0 || bus.out_vld !== 2'b00) begin
      errors++; $display("FAIL pp_drained got cnt=%0d vld=%b exp 0 00", bus.count, bus.out_vld); end
  endtask

  task automatic test_fill();
    for (int g = 0; g < 4; g++) begin
      set_in(1, 4, 32'h300 + 32'(16 * g), 0, 0);
      checks++; if (bus.in_rdy !== 1'b1) begin errors++; $display("FAIL fill_rdy_%0d got %b exp 1", g, bus.in_rdy); end
      tick();
    end
    set_in(0, 0, 0, 0, 0);
    checks++; if (bus.count !== 5'd16 || bus.in_rdy !== 1'b0) begin
      errors++; $display("FAIL fill_full got cnt=%0d rdy=%b exp 16 0", bus.count, bus.in_rdy); end
    set_in(1, 4, 32'hdead0000, 0, 0); tick(); set_in(0, 0, 0, 0, 0);
    checks++; if (bus.count !== 5'd16) begin errors++; $display("FAIL fill_ignored got %0d exp 16", bus.count); end
    for (int k = 0; k < 2; k++) begin
      set_in(0, 0, 0, 2, 0);
      checks++; if (bus.out_pc[0] !== sb[0].pc || bus.out_pc[1] !== sb[1].pc || bus.out_instr[0] !== sb[0].instr) begin
        errors++; $display("FAIL fill_pop_%0d got pc=%h,%h exp %h,%h", k, bus.out_pc[0], bus.out_pc[1], sb[0].pc, sb[1].pc); end
      tick();
    end
    set_in(0, 0, 0, 0, 0);
    checks++; if (bus.count !== 5'd12 || bus.in_rdy !== 1'b1 || bus.out_pc[0] !== 32'h310) begin
      errors++; $display("FAIL fill_after_pop got cnt=%0d rdy=%b pc=%h exp 12 1 310", bus.count, bus.in_rdy, bus.out_pc[0]); end
    for (int k = 0; k < 8; k++) begin
      if (sb.size() > 0) begin
        set_in(0, 0, 0, (sb.size() >= 2) ? 2 : 1, 0);
        checks++; if (bus.out_pc[0] !== sb[0].pc || bus.out_instr[0] !== sb[0].instr) begin
          errors++; $display("FAIL fill_drain_%0d got pc=%h exp %h", k, bus.out_pc[0], sb[0].pc); end
        tick();
      end
    end
    set_in(0, 0, 0, 0, 0);
    checks++; if (bus.count !== 5'd0) begin errors++; $display("FAIL fill_empty got %0d exp 0", bus.count); end
  endtask

  task automatic test_wrap();
    set_in(1, 4, 32'h1000, 0, 0); tick();
    set_in(1, 4, 32'h1010, 0, 0); tick();
    set_in(1, 2, 32'h1020, 0, 0); tick();
    for (int k = 0; k < 5; k++) begin
      set_in(0, 0, 0, 2, 0);
      checks++; if (bus.out_pc[0] !== sb[0].pc || bus.out_pc[1] !== sb[1].pc) begin
        errors++; $display("FAIL wrap_pre_%0d got pc=%h,%h exp %h,%h", k, bus.out_pc[0], bus.out_pc[1], sb[0].pc, sb[1].pc); end
      tick();
    end
    set_in(1, 3, 32'h200, 0, 0); tick();
    set_in(0, 0, 0, 2, 0);
    checks++; if (bus.out_pc[0] !== 32'h200 || bus.out_pc[1] !== 32'h204 || bus.out_instr[1] !== sb[1].instr) begin
      errors++; $display("FAIL wrap_first got pc=%h,%h exp 200,204", bus.out_pc[0], bus.out_pc[1]); end
    tick();
    set_in(0, 0, 0, 1, 0);
    checks++; if (bus.out_pc[0] !== 32'h208 || bus.out_instr[0] !== sb[0].instr || bus.out_vld !== 2'b01 || bus.out_pc[1] !== 32'd0) begin
      errors++; $display("FAIL wrap_last got pc=%h vld=%b pc1=%h exp 208 01 0", bus.out_pc[0], bus.out_vld, bus.out_pc[1]); end
    tick(); set_in(0, 0, 0, 0, 0);
    checks++; if (bus.count !== 5'd0) begin errors++; $display("FAIL wrap_empty got %0d exp 0", bus.count); end
  endtask

  task automatic test_flush();
    set_in(1, 4, 32'h500, 0, 0); tick();
    set_in(1, 2, 32'h510, 0, 0); tick();
    set_in(1, 4, 32'h600, 2, 1);
    checks++; if (bus.count !== 5'd6) begin errors++; $display("FAIL flush_pre got %0d exp 6", bus.count); end
    tick(); set_in(0, 0, 0, 0, 0);
    checks++; if (bus.count !== 5'd0 || bus.out_vld !== 2'b00 || bus.out_pc[0] !== 32'd0 || bus.in_rdy !== 1'b1) begin
      errors++; $display("FAIL flush_state got cnt=%0d vld=%b pc=%h rdy=%b exp 0 00 0 1", bus.count, bus.out_vld, bus.out_pc[0], bus.in_rdy); end
    set_in(1, 1, 32'h700, 0, 0); tick(); set_in(0, 0, 0, 0, 0);
    checks++; if (bus.count !== 5'd1 || bus.out_pc[0] !== 32'h700 || bus.out_instr[0] !== sb[0].instr) begin
      errors++; $display("FAIL flush_restart got cnt=%0d pc=%h exp 1 700", bus.count, bus.out_pc[0]); end
    set_in(0, 0, 0, 1, 0); tick(); set_in(0, 0, 0, 0, 0);
  endtask

`ifdef FETCH_QUEUE_BYPASS_EN
  task automatic test_bypass();
    set_in(1, 1, 32'h40, 1, 0);
    checks++; if (bus.out_vld !== 2'b01 || bus.out_pc[0] !== 32'h40 || bus.out_instr[0] !== bus.instr_in[0]) begin
      errors++; $display("FAIL bypass_same_cycle got vld=%b pc=%h exp 01 40", bus.out_vld, bus.out_pc[0]); end
    tick(); set_in(0, 0, 0, 0, 0);
    checks++; if (bus.count !== 5'd0) begin errors++; $display("FAIL bypass_consumed got %0d exp 0", bus.count); end
    set_in(1, 3, 32'h80, 1, 0);
    checks++; if (bus.out_vld !== 2'b11 || bus.out_pc[1] !== 32'h84) begin
      errors++; $display("FAIL bypass_two got vld=%b pc1=%h exp 11 84", bus.out_vld, bus.out_pc[1]); end
    tick(); set_in(0, 0, 0, 0, 0);
    checks++; if (bus.count !== 5'd2 || bus.out_pc[0] !== 32'h84 || bus.out_instr[0] !== sb[0].instr) begin
      errors++; $display("FAIL bypass_stored got cnt=%0d pc=%h exp 2 84", bus.count, bus.out_pc[0]); end
    set_in(0, 0, 0, 2, 0); tick(); set_in(0, 0, 0, 0, 0);
  endtask
`else
  task automatic test_no_bypass();
    set_in(1, 2, 32'h40, 0, 0);
    checks++; if (bus.out_vld !== 2'b00 || bus.out_pc[0] !== 32'd0) begin
      errors++; $display("FAIL nobypass_same_cycle got vld=%b pc=%h exp 00 0", bus.out_vld, bus.out_pc[0]); end
    tick(); set_in(0, 0, 0, 0, 0);
    checks++; if (bus.count !== 5'd2 || bus.out_pc[0] !== 32'h40 || bus.out_pc[1] !== 32'h44) begin
      errors++; $display("FAIL nobypass_next got cnt=%0d pc=%h,%h exp 2 40,44", bus.count, bus.out_pc[0], bus.out_pc[1]); end
    set_in(0, 0, 0, 2, 0); tick(); set_in(0, 0, 0, 0, 0);
  endtask
`endif

  initial begin
    test_reset();
    test_push_pop();
    test_fill();
    test_wrap();
    test_flush();
`ifdef FETCH_QUEUE_BYPASS_EN
    test_bypass();
`else
    test_no_bypass();
`endif
    test_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
